multu_hilo_unit: RTL and testbench
==================================

// Module: multu_hilo_unit
// PURPOSE
//  Iterative unsigned multiplier plus HI/LO register pair serving the pipelined CPU's MULTU/MFHI/MFLO.
//  - Responder side of the EX-stage multiply interface: the CPU issues a start, this block computes over several cycles.
//  - Also requests pipeline stalls when a dependent MFHI/MFLO, or a second MULTU, reaches EX before the product is ready.
// PARAMETERS
//  WIDTH  32  operand width; the product is 2*WIDTH bits, split into hi (upper) and lo (lower).
// PORTS
//  clk     in   1      system clock, rising edge
//  reset   in   1      asynchronous, active-high reset
//  start   in   1      MULTU in EX; sampled on the rising edge
//  src_a   in   WIDTH  multiplicand (rs), sampled when start is accepted
//  src_b   in   WIDTH  multiplier (rt), sampled when start is accepted
//  mf_req  in   1      MFHI or MFLO in EX
//  busy    out  1      multiply in progress
//  done    out  1      one-cycle pulse: a new product has just been written to hi/lo
//  stall   out  1      hold IF/ID/EX this cycle
//  hi      out  WIDTH  HI register (architectural)
//  lo      out  WIDTH  LO register (architectural)
// BEHAVIOUR
//  Interface and reset:
//  - One clock domain. Reset is asynchronous and active-high.
//  - Reset values: busy=0, done=0, hi=0, lo=0, state=IDLE. stall is 0 while reset is high.
//  State machine:
//  - States: IDLE, RUN, FIN.
//  - IDLE: start=1 at an edge accepts the operation.
//    - Latch src_a and src_b, clear the accumulator and step counter, go to RUN.
//  - RUN: one shift-add step per cycle, consuming multiplier bit i at step i (unsigned).
//    - After step WIDTH-1, go to FIN.
//  - FIN (one cycle): {hi,lo} <= full 2*WIDTH product, done=1, busy=0.
//    - Next state is IDLE, or RUN if start=1 in FIN; back-to-back issue is allowed.
//  Timing and latency:
//  - busy = (state==RUN), a registered output.
//  - busy is high for exactly WIDTH cycles, starting the cycle after the accepting edge.
//  - done is high in the following cycle. Start edge to done cycle = WIDTH+1 edges.
//  - hi/lo keep their old values for the whole of RUN and change only on the FIN entry edge (atomic update).
//  - No carry is lost: the accumulator is WIDTH+1 bits wide, so 0xFFFFFFFF^2 is exact.
//  Stall and boundary conditions:
//  - stall = busy & (mf_req | start), combinational.
//  - A start seen while busy is NOT accepted. The stall holds the instruction in EX, and it is re-presented later.
//  - stall is 0 in the FIN cycle, so an MFHI/MFLO in that cycle reads the new hi/lo values.
//  - mf_req never changes state, and hi/lo are never written other than by the FIN entry.
//  - Reset mid-operation aborts the operation immediately: no done pulse, hi=lo=0, state=IDLE.
//  - start and mf_req together in IDLE: the start is accepted, stall=0 in that cycle, and mf_req reads the old hi/lo.
// CONFIGURATION
//  MULTU_EARLY_EXIT_EN:
//  - Defined: in RUN, if the unconsumed multiplier bits after the current step are all zero, go to FIN on the next edge.
//    - busy then lasts 1 to WIDTH cycles (index of the highest set bit of src_b, plus 1; minimum 1).
//    - The product is unchanged.
//  - Undefined: fixed WIDTH-cycle RUN regardless of the operands. This is the default, with deterministic latency.
// TESTING
//  - Basic product: src_a=3, src_b=5, start 1 cycle -> busy=1 for 32 cycles, then done=1 with hi=0, lo=15.
//  - Maximum operands: 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; previous hi/lo are held throughout RUN.
//  - Stall, load-use style: mf_req=1 held from the cycle after start -> stall=1 for all 32 busy cycles, stall=0 in the done cycle, and hi/lo there show the new product.
//  - Start while busy: start(7,9), then start(2,2) asserted during RUN -> stall=1 while busy, the second start is not accepted, the first result is 0/63.
//    - Re-presenting (2,2) in the FIN cycle gives done 33 cycles later with lo=4.
//  - Reset mid-operation: reset at RUN cycle 10 -> busy=0, hi=lo=0 at once, no done pulse afterwards.
//  - Early exit: src_b=1 -> with MULTU_EARLY_EXIT_EN, busy=1 cycle and done on the 2nd cycle; without it, busy=32 cycles.
//    - In both cases lo=src_a and hi=0.

Source files
------------

// File: rtl/multu_hilo_unit.sv
// multu_hilo_unit: iterative unsigned shift-add multiplier with the architectural HI/LO pair.
// Latency: WIDTH busy cycles after the accepting edge, then a one-cycle done (FIN) with HI/LO updated.
// Backpressure: stall = busy & (mf_req | start); a start while busy is ignored and must be re-presented.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   start          MULTU in EX, accepted in IDLE or FIN
//   src_a, src_b   multiplicand / multiplier, latched on the accepting edge
//   mf_req         MFHI/MFLO in EX (only affects stall)
//   busy           multiply in progress (state == RUN)
//   done           one-cycle pulse while hi/lo hold a fresh product (state == FIN)
//   stall          hold IF/ID/EX this cycle
//   hi, lo         upper / lower halves of the last completed product
//
// Build option: define MULTU_EARLY_EXIT_EN to leave RUN as soon as the remaining
// multiplier bits are all zero (busy = index of highest set bit of src_b + 1, minimum 1).
module multu_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mf_req,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // upper half of the running product
  logic [WIDTH-1:0] mlr_q, mlr_d;   // product low bits shift in from the top, multiplier bits leave at bit 0
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]     sum;          // one extra bit keeps the carry of every add
  logic [WIDTH-1:0]   step_acc;
  logic [WIDTH-1:0]   step_mlr;
  logic               last_step;
  logic [2*WIDTH-1:0] product;

  // One shift-add step: add the multiplicand if the current multiplier bit is set,
  // then shift the {carry, acc, mlr} chain right by one.
  always_comb begin
    sum      = {1'b0, acc_q} + (mlr_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    step_acc = sum[WIDTH:1];
    step_mlr = {sum[0], mlr_q[WIDTH-1:1]};
  end

`ifdef MULTU_EARLY_EXIT_EN
  // Bits [WIDTH-1-cnt:1] of mlr_q are the multiplier bits not yet consumed after this step.
  logic [WIDTH-1:0] rem_mask;
  assign rem_mask  = ({WIDTH{1'b1}} >> cnt_q) & ~WIDTH'(1);
  assign last_step = (cnt_q == CW'(WIDTH-1)) || ((mlr_q & rem_mask) == '0);
  // Skipped steps would only have shifted zeros in; apply that shift in one go.
  assign product   = {step_acc, step_mlr} >> (CW'(WIDTH-1) - cnt_q);
`else
  assign last_step = (cnt_q == CW'(WIDTH-1));
  assign product   = {step_acc, step_mlr};
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    acc_d   = acc_q;
    mlr_d   = mlr_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          state_d = RUN;
          a_d     = src_a;
          mlr_d   = src_b;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = step_acc;
        mlr_d = step_mlr;
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          // HI/LO change only here, so readers never see a partial product.
          state_d      = FIN;
          {hi_d, lo_d} = product;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      acc_q   <= '0;
      mlr_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      mlr_q   <= mlr_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == FIN);
  assign stall = busy & (mf_req | start);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_multu_hilo_unit.sv
// tb_multu_hilo_unit: directed checks of multu_hilo_unit (WIDTH=32).
// Latency: expects WIDTH busy cycles (or the early-exit count when that build option is set), then done.
// Backpressure: checks stall behaviour for MFHI/MFLO and for a start presented while busy.
module tb_multu_hilo_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        mf_req;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk  = 0;
  int n_pass = 0;

  multu_hilo_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .src_a  (src_a),
    .src_b  (src_b),
    .mf_req (mf_req),
    .busy   (busy),
    .done   (done),
    .stall  (stall),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected busy length for multiplier b.
  function automatic int exp_cycles(input logic [31:0] b);
    int h;
    h = 0;
    for (int i = 0; i < 32; i++) if (b[i]) h = i;
`ifdef MULTU_EARLY_EXIT_EN
    return h + 1;
`else
    return (h >= 0) ? 32 : 32;
`endif
  endfunction

  // Issue a multiply from IDLE or FIN, follow it through RUN and stop in the done cycle.
  // ph/pl: hi/lo expected to be held until completion.
  task automatic do_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el,
                         input logic [31:0] ph, input logic [31:0] pl, input logic mf);
    int n;
    start = 1'b1; src_a = a; src_b = b;
    #1;
    chk({tag, "_issue_stall"}, 64'(stall), 64'd0);
    chk({tag, "_issue_hilo"}, {hi, lo}, {ph, pl});
    step();
    start = 1'b0; mf_req = mf;
    #1;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      chk({tag, "_run_stall"}, 64'(stall), 64'(mf));
      chk({tag, "_run_hilo_held"}, {hi, lo}, {ph, pl});
      n++;
      step();
      #1;
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'(exp_cycles(b)));
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_done_stall"}, 64'(stall), 64'd0);
    chk({tag, "_product"}, {hi, lo}, {eh, el});
    mf_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic seen;
    reset = 1'b1; start = 1'b1; mf_req = 1'b1; src_a = '0; src_b = '0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    start = 1'b0; mf_req = 1'b0;
    step();
    step();
    reset = 1'b0;

    // mf_req alone in IDLE changes nothing.
    mf_req = 1'b1;
    #1;
    chk("mf_idle_stall", 64'(stall), 64'd0);
    step();
    chk("mf_idle_busy", 64'(busy), 64'd0);
    mf_req = 1'b0;

    // Basic product.
    do_mult("basic", 32'd3, 32'd5, 32'd0, 32'd15, 32'd0, 32'd0, 1'b0);
    step();
    chk("basic_done_pulse", 64'(done), 64'd0);
    chk("basic_kept", {hi, lo}, {32'd0, 32'd15});

    // Maximum operands with MFHI/MFLO held from the cycle after start.
    do_mult("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
            32'd0, 32'd15, 1'b1);
    step();

    // Start while busy: first (7,9), then (2,2) held during RUN.
    start = 1'b1; src_a = 32'd7; src_b = 32'd9;
    step();
    src_a = 32'd2; src_b = 32'd2;
    #1;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      chk("sb_run_stall", 64'(stall), 64'd1);
      n++;
      step();
      #1;
    end
    chk("sb_busy_cycles", 64'(n), 64'(exp_cycles(32'd9)));
    chk("sb_done", 64'(done), 64'd1);
    chk("sb_first_product", {hi, lo}, {32'd0, 32'd63});
    // Re-present (2,2) in the FIN cycle: back-to-back issue.
    do_mult("sb_second", 32'd2, 32'd2, 32'd0, 32'd4, 32'd0, 32'd63, 1'b0);
    step();

    // Reset in RUN cycle 10.
    start = 1'b1; src_a = 32'd1234; src_b = 32'd5678;
    step();
    start = 1'b0;
    repeat (9) step();
    chk("mid_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_hilo", {hi, lo}, 64'd0);
    step();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
      step();
    end
    chk("mid_no_done", 64'(seen), 64'd0);

    // Multiplier of 1: early exit candidate.
    do_mult("one", 32'hDEAD_BEEF, 32'd1, 32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 1'b0);
    step();

    // start and mf_req together in IDLE: start accepted without stall, old hi/lo visible.
    mf_req = 1'b1;
    do_mult("start_mf", 32'd6, 32'd7, 32'd0, 32'd42, 32'd0, 32'hDEAD_BEEF, 1'b1);
    step();
    chk("final_idle_busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
